mult_accumulator: RTL

Downstream consumer of the multiplier ALU's 6-bit product (`Doutmult`). It accumulates a block of N products into a saturating sum, then presents the sum on a valid/ready output handshake. It throttles the upstream with `din_ready` while a result is held. It turns the single-shot multiplier into a multiply-accumulate path for small dot products.

---
 rtl/mult_acc_pkg.sv | 15 +
 rtl/mult_acc_satadd.sv | 24 ++
 rtl/mult_accumulator.sv | 99 +++++++++
 3 files changed

// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the multiply-accumulate block that follows
// the multiplier ALU.
package mult_acc_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

   // Opcode on which the upstream ALU asserts din_valid.
   localparam logic [1:0] OP_MUL = 2'b11;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mult_acc_satadd.sv
// Combinational AW-bit unsigned adder that clamps to all-ones on carry-out.
module mult_acc_satadd #(
   parameter int AW = 8
) (
   input  logic [AW-1:0] a,
   input  logic [AW-1:0] b,
   output logic [AW-1:0] sum,
   output logic          ovf
);

   logic [AW:0] full_sum;

   assign full_sum = {1'b0, a} + {1'b0, b};
   assign ovf      = full_sum[AW];

   // Carry-out forces every result bit high, giving 2^AW - 1.
   genvar gi;
   generate
      for (gi = 0; gi < AW; gi = gi + 1) begin : g_clamp
         assign sum[gi] = full_sum[gi] | ovf;
      end
   endgenerate

endmodule

// File: rtl/mult_accumulator.sv
// Accumulates blocks of up to N multiplier products into a saturating sum and
// offers each completed block on a valid/ready output.
module mult_accumulator
   import mult_acc_pkg::*;
#(
   parameter int PW = 6,
   parameter int N  = 4,
   parameter int AW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PW-1:0]    din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             flush,
   output logic [AW-1:0]    dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             sat,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

   acc_state_t       state_reg;
   logic [AW-1:0]    acc_reg;
   logic [AW-1:0]    dout_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             sat_reg;

   logic [AW-1:0]    din_ext;
   logic [AW-1:0]    add_sum;
   logic             add_ovf;
   logic [CNT_W-1:0] cnt_next;
   logic             accept;

   assign din_ext  = AW'(din);
   assign cnt_next = cnt_reg + 1'b1;

   mult_acc_satadd #(
      .AW (AW)
   ) u_satadd (
      .a   (acc_reg),
      .b   (din_ext),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   // Handshake flags come from the state register; only rst may gate them.
   assign din_ready  = (state_reg == ACCUM) && !rst;
   assign dout_valid = (state_reg == HOLD);
   assign accept     = din_valid && din_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ACCUM;
         acc_reg   <= '0;
         dout_reg  <= '0;
         cnt_reg   <= '0;
         sat_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (accept) begin
                  acc_reg <= add_sum;
                  cnt_reg <= cnt_next;
                  if (add_ovf) begin
                     sat_reg <= 1'b1;
                  end
                  // A same-cycle flush closes the block after including this product.
                  if ((cnt_next == N_CNT) || flush) begin
                     dout_reg  <= add_sum;
                     state_reg <= HOLD;
                  end
               end else if (flush && (cnt_reg != '0)) begin
                  dout_reg  <= acc_reg;
                  state_reg <= HOLD;
               end
            end
            HOLD: begin
               if (dout_ready) begin
                  state_reg <= ACCUM;
                  acc_reg   <= '0;
                  cnt_reg   <= '0;
                  sat_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg <= ACCUM;
            end
         endcase
      end
   end

   assign dout = dout_reg;
   assign sat  = sat_reg;
   assign cnt  = cnt_reg;

endmodule
